// File: rtl/seq_barrel_shifter.sv
// Sequential barrel shifter: one log-stage per clock, so every request takes exactly SW cycles
// regardless of shift amount, followed by a valid/ready result handshake.
module seq_barrel_shifter #(
  parameter int WIDTH = 32,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    shamt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [SW-1:0] KLast  = SW'(SW - 1);
  localparam logic [SW:0]   WidthC = (SW+1)'(WIDTH);

  state_e           state_q, state_d;
  logic [SW-1:0]    k_q, k_d;
  logic [SW-1:0]    shamt_q, shamt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW:0]      stageAmt;
  logic [WIDTH-1:0] stageRes;
  logic             accept;

  assign accept = (state_q == IDLE) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = SHIFT;
      SHIFT:   if (k_q == KLast)  state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    dout      = (state_q == DONE) ? work_q : '0;
    out_err   = (state_q == DONE) && (op_q > 3'd4);
  end

  // Stage k moves the working value by 2^k; SRA relies on the intermediate MSB
  // still being the operand's original MSB, which every earlier SRA stage preserves.
  always_comb begin
    stageAmt = (SW+1)'(1) << k_q;
    stageRes = work_q;
    case (op_q)
      3'd0:    stageRes = work_q << stageAmt;
      3'd1:    stageRes = work_q >> stageAmt;
      3'd2:    stageRes = $unsigned($signed(work_q) >>> stageAmt);
      3'd3:    stageRes = (work_q << stageAmt) | (work_q >> (WidthC - stageAmt));
      3'd4:    stageRes = (work_q >> stageAmt) | (work_q << (WidthC - stageAmt));
      default: stageRes = work_q;
    endcase
  end

  always_comb begin
    k_d     = k_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    work_d  = work_q;
    if (accept) begin
      k_d     = '0;
      shamt_d = shamt;
      op_d    = op;
      work_d  = din;
    end else if (state_q == SHIFT) begin
      if (shamt_q[k_q]) work_d = stageRes;
      k_d = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q     <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      work_q  <= '0;
    end else begin
      k_q     <= k_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      work_q  <= work_d;
    end
  end

endmodule
